// File: rtl/downcounter_4bits.sv
// Loadable down counter with wrap / stop / auto-reload behaviour at zero.
// Underflow is reported by a one-cycle registered borrow pulse; zero decodes q.
module downcounter_4bits #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow
);

  localparam logic [1:0] MODE_WRAP   = 2'd0;
  localparam logic [1:0] MODE_STOP   = 2'd1;
  localparam logic [1:0] MODE_RELOAD = 2'd2;

  logic [WIDTH-1:0] rld;
  logic [WIDTH-1:0] q_next;
  logic             borrow_next;

  // Mode 3 is reserved and falls into the wrap branch through the default arm.
  always_comb begin
    q_next      = q;
    borrow_next = 1'b0;
    if (load) begin
      q_next = d;
    end else if (down) begin
      if (q != '0) begin
        q_next = q - 1'b1;
      end else begin
        case (mode)
          MODE_STOP: begin
            q_next = '0;
          end
          MODE_RELOAD: begin
            q_next      = rld;
            borrow_next = 1'b1;
          end
          MODE_WRAP: begin
            q_next      = '1;
            borrow_next = 1'b1;
          end
          default: begin
            q_next      = '1;
            borrow_next = 1'b1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q      <= '0;
      rld    <= '0;
      borrow <= 1'b0;
    end else begin
      q      <= q_next;
      borrow <= borrow_next;
      if (load) begin
        rld <= d;
      end
    end
  end

  assign zero = (q == '0);

endmodule

// File: tb/tb_downcounter_4bits.sv
// Scoreboard bench for downcounter_4bits: expected q/borrow pushed when a cycle
// is driven, popped and compared just after the clock edge that produces them.
module tb_downcounter_4bits;

  logic       clk;
  logic       rst;
  logic       down;
  logic       load;
  logic [3:0] d;
  logic [1:0] mode;
  logic [3:0] q;
  logic       zero;
  logic       borrow;

  typedef struct packed {
    logic [3:0] q;
    logic       b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  downcounter_4bits #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .down   (down),
    .load   (load),
    .d      (d),
    .mode   (mode),
    .q      (q),
    .zero   (zero),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, compare 1 ns after the rising edge.
  task automatic step(input logic dn, input logic ld, input logic [3:0] dv,
                      input logic [1:0] md, input logic [3:0] eq, input logic eb);
    exp_t e;
    @(negedge clk);
    down = dn;
    load = ld;
    d    = dv;
    mode = md;
    e.q  = eq;
    e.b  = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("q", int'(q), int'(e.q));
      check("borrow", int'(borrow), int'(e.b));
      check("zero", int'(zero), int'(e.q == 4'd0));
      $display("cyc down=%0b load=%0b d=%0d mode=%0d -> q=%0d borrow=%0b zero=%0b",
               dn, ld, dv, md, q, borrow, zero);
    end
  endtask

  // Pulse reset between edges and check the asynchronous clear before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    down = 1'b0;
    load = 1'b0;
    rst  = 1'b0;
    #1;
    check({tag, "_q"}, int'(q), 0);
    check({tag, "_zero"}, int'(zero), 1);
    check({tag, "_borrow"}, int'(borrow), 0);
    $display("async reset %s -> q=%0d borrow=%0b zero=%0b", tag, q, borrow, zero);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    down = 1'b0;
    load = 1'b0;
    d    = 4'd0;
    mode = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", int'(q), 0);
    check("reset_zero", int'(zero), 1);
    check("reset_borrow", int'(borrow), 0);
    @(negedge clk);
    rst = 1'b1;

    // Wrap mode: 5,4,3,2,1,0,15,14
    step(0, 1, 4'd5, 2'd0, 4'd5, 0);
    for (int i = 4; i >= 0; i--) step(1, 0, 4'd0, 2'd0, 4'(i), 0);
    step(1, 0, 4'd0, 2'd0, 4'd15, 1);
    step(1, 0, 4'd0, 2'd0, 4'd14, 0);

    // Stop mode: 3,2,1,0,0,0 with no borrow
    step(0, 1, 4'd3, 2'd1, 4'd3, 0);
    step(1, 0, 4'd0, 2'd1, 4'd2, 0);
    step(1, 0, 4'd0, 2'd1, 4'd1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 4'd0, 2'd1, 4'd0, 0);

    // Auto-reload: 2,1,0,2,1,0,2
    step(0, 1, 4'd2, 2'd2, 4'd2, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 4'd0, 2'd2, 4'd1, 0);
      step(1, 0, 4'd0, 2'd2, 4'd0, 0);
      step(1, 0, 4'd0, 2'd2, 4'd2, 1);
    end

    // Enable gating from 9
    step(0, 1, 4'd9, 2'd0, 4'd9, 0);
    step(1, 0, 4'd0, 2'd0, 4'd8, 0);
    step(0, 0, 4'd0, 2'd0, 4'd8, 0);
    step(1, 0, 4'd0, 2'd0, 4'd7, 0);

    // Load beats underflow on the same edge
    step(0, 1, 4'd1, 2'd0, 4'd1, 0);
    step(1, 0, 4'd0, 2'd0, 4'd0, 0);
    step(1, 1, 4'd12, 2'd0, 4'd12, 0);

    // Reserved mode wraps like mode 0
    step(0, 1, 4'd0, 2'd3, 4'd0, 0);
    step(1, 0, 4'd0, 2'd3, 4'd15, 1);

    // Async reset at q=6 in mode 2 clears rld as well
    step(0, 1, 4'd7, 2'd2, 4'd7, 0);
    step(1, 0, 4'd0, 2'd2, 4'd6, 0);
    async_reset("rst_mid");
    step(1, 0, 4'd0, 2'd2, 4'd0, 1);
    step(1, 0, 4'd0, 2'd2, 4'd0, 1);

    // Async reset while borrow is high
    step(0, 1, 4'd1, 2'd0, 4'd1, 0);
    step(1, 0, 4'd0, 2'd0, 4'd0, 0);
    step(1, 0, 4'd0, 2'd0, 4'd15, 1);
    async_reset("rst_borrow");

    // Zero reload value: q stays 0, borrow high every cycle
    step(0, 1, 4'd0, 2'd2, 4'd0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 4'd0, 2'd2, 4'd0, 1);
    step(0, 0, 4'd0, 2'd2, 4'd0, 0);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
